seq_input_conditioner: RTL

//  Front end for the serial-input sequence-detector FSM on the Vaman board.
//  - Synchronises and debounces the raw slide-switch/button input x_raw.
//  - Generates a one-cycle sample strobe from clk, replacing the divided fabric clock.
//  - Presents one clean sampled bit per strobe. The downstream detector advances only when x_valid=1.

---
 rtl/seq_input_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/seq_input_conditioner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_input_pkg.sv
// Shared types and default constants for the serial-input conditioner.
package seq_input_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } deb_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 200000;
    localparam int unsigned TICK_DIV_DEF        = 20000001;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/seq_input_conditioner.sv
// Synchronise, debounce and strobe-sample a bouncy switch input for the sequence detector.
// Optional SEQ_EDGE_EN adds registered rise/fall pulses on the debounced level.
module seq_input_conditioner
    import seq_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic x_raw,
    output logic x_clean,
    output logic tick,
    output logic x_bit,
    output logic x_valid,
    output logic x_rise,
    output logic x_fall
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TCNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);

    logic             x_sync;
    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             clean_next;
    logic [TCNT_W-1:0] tcnt;
    logic             tick_last;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (x_raw),
        .q   (x_sync)
    );

    // Debounce state register; x_clean is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOW;
            cnt     <= '0;
            x_clean <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            x_clean <= clean_next;
        end
    end

    // A pending level must hold for DEBOUNCE_CYCLES edges; any reversion restarts it.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = x_clean;
        case (state)
            LOW: begin
                if (x_sync) begin
                    state_next = PEND_HIGH;
                    cnt_next   = '0;
                end
            end
            PEND_HIGH: begin
                if (!x_sync) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HIGH;
                    clean_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!x_sync) begin
                    state_next = PEND_LOW;
                    cnt_next   = '0;
                end
            end
            PEND_LOW: begin
                if (x_sync) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = LOW;
                    clean_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
                clean_next = 1'b0;
            end
        endcase
    end

    assign tick_last = (tcnt == TCNT_LAST);

    // Free-running strobe; the sample takes x_clean as it was before the strobe edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            tick    <= 1'b0;
            x_valid <= 1'b0;
            x_bit   <= 1'b0;
        end else begin
            tcnt    <= tick_last ? '0 : tcnt + TCNT_W'(1);
            tick    <= tick_last;
            x_valid <= tick_last;
            if (tick_last) begin
                x_bit <= x_clean;
            end
        end
    end

`ifdef SEQ_EDGE_EN
    logic clean_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_d <= 1'b0;
            x_rise  <= 1'b0;
            x_fall  <= 1'b0;
        end else begin
            clean_d <= x_clean;
            x_rise  <= x_clean & ~clean_d;
            x_fall  <= ~x_clean & clean_d;
        end
    end
`else
    assign x_rise = 1'b0;
    assign x_fall = 1'b0;
`endif

endmodule
